// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants for the 4-digit 7-segment scan driver:
//                hex segment table, blank/off patterns and slot state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a}; entry N is the pattern for hex digit N.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [0:0] {
        DEAD = 1'b0,
        ON   = 1'b1
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/hex_to_seg7.sv
// ============================================================================
//  Module      : hex_to_seg7
//  Description : Combinational nibble to active-low 7-segment pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_to_seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);
    import seg7_pkg::*;

    assign seg_n = SEG_TABLE[nibble];

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Multiplexed 4-digit 7-segment driver with dead-time between
//                digits and frame-boundary double-buffered display updates.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int DEAD_CYCLES  = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        frame_done
);
    import seg7_pkg::*;

    localparam int            CW         = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] C_LAST     = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] C_DEAD_END = CW'(DEAD_CYCLES - 1);

    scan_state_t   r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_idx, w_idx_nxt;
    logic          w_last;
    logic          w_frame_end;

    logic [15:0]   r_shd_value, r_act_value;
    logic [3:0]    r_shd_dp, r_act_dp;
    logic          r_shd_blank_lz, r_act_blank_lz;

    logic [3:0]    w_nibble;
    logic [6:0]    w_seg_dec;
    logic          w_lz;
    logic [3:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_dp_nxt;
    logic          w_frame_done_nxt;

    logic [6:0]    r_seg_n;
    logic          r_dp_n;
    logic [3:0]    r_an_n;
    logic          r_frame_done;

    assign w_last      = (r_cnt == C_LAST);
    assign w_frame_end = w_last && (r_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DEAD;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        if (w_last) begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = DEAD;
        end else if (r_state == DEAD && r_cnt == C_DEAD_END) begin
            w_state_nxt = ON;
        end
    end

    // Outputs are decoded from the next slot state so the registered pins
    // line up with the state register; anode and segments share one edge.
    assign w_nibble = r_act_value[{w_idx_nxt, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (w_nibble),
        .seg_n  (w_seg_dec)
    );

    always_comb begin
        w_lz = 1'b0;
        case (w_idx_nxt)
            2'd3:    w_lz = (r_act_value[15:12] == 4'd0);
            2'd2:    w_lz = (r_act_value[15:8]  == 8'd0);
            2'd1:    w_lz = (r_act_value[15:4]  == 12'd0);
            default: w_lz = 1'b0;
        endcase
    end

    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_BLANK;
        w_dp_nxt  = 1'b1;
        if (w_state_nxt == ON) begin
            w_an_nxt  = ~(4'b0001 << w_idx_nxt);
            w_seg_nxt = (r_act_blank_lz && w_lz) ? SEG_BLANK : w_seg_dec;
            w_dp_nxt  = ~r_act_dp[w_idx_nxt];
        end
    end

    assign w_frame_done_nxt = (w_cnt_nxt == C_LAST) && (w_idx_nxt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_n       <= AN_OFF;
            r_seg_n      <= SEG_BLANK;
            r_dp_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an_n       <= w_an_nxt;
            r_seg_n      <= w_seg_nxt;
            r_dp_n       <= w_dp_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // A load in the boundary cycle bypasses the shadow so it is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shd_value    <= 16'd0;
            r_shd_dp       <= 4'd0;
            r_shd_blank_lz <= 1'b0;
            r_act_value    <= 16'd0;
            r_act_dp       <= 4'd0;
            r_act_blank_lz <= 1'b0;
        end else begin
            if (load) begin
                r_shd_value    <= value;
                r_shd_dp       <= dp_in;
                r_shd_blank_lz <= blank_lz;
            end
            if (w_frame_end) begin
                r_act_value    <= load ? value    : r_shd_value;
                r_act_dp       <= load ? dp_in    : r_shd_dp;
                r_act_blank_lz <= load ? blank_lz : r_shd_blank_lz;
            end
        end
    end

    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign an_n       = r_an_n;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Directed bench for seg7_scan_driver (8-clock slots, 2 dead).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int vectors    = 0;
    int miscompares = 0;

    seg7_scan_driver #(
        .DIGIT_CYCLES (8),
        .DEAD_CYCLES  (2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        vectors++;
        assert (obs === expd) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expd);
        end
    endtask

    task automatic wait_frame_done();
        bit found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (frame_done === 1'b1) found = 1'b1;
        end
        check("frame_done_seen", {31'd0, found}, 32'd1);
    endtask

    // Called in a frame_done cycle; checks every cycle of the following frame
    // and optionally issues a one-cycle load at position ld_k of that frame.
    task automatic check_frame(input string tag, input logic [3:0][6:0] segs,
                               input logic [3:0] dps, input bit ld_en,
                               input int ld_k, input logic [15:0] ld_val);
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        int         idx;
        int         c;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            load = 1'b0;
            idx  = k / 8;
            c    = k % 8;
            if (c < 2) begin
                ea = 4'hF;
                es = 7'h7F;
                ed = 1'b1;
            end else begin
                ea = ~(4'b0001 << idx);
                es = segs[idx];
                ed = ~dps[idx];
            end
            check({tag, "_an"},  {28'd0, an_n},       {28'd0, ea});
            check({tag, "_seg"}, {25'd0, seg_n},      {25'd0, es});
            check({tag, "_dp"},  {31'd0, dp_n},       {31'd0, ed});
            check({tag, "_fd"},  {31'd0, frame_done}, {31'd0, (k == 31)});
            if (ld_en && k == ld_k) begin
                load     = 1'b1;
                value    = ld_val;
                dp_in    = 4'd0;
                blank_lz = 1'b0;
            end
        end
    endtask

    initial begin
        int pulses;
        int last;
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'd0;
        dp_in    = 4'd0;
        blank_lz = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_an",  {28'd0, an_n},       32'hF);
        check("rst_seg", {25'd0, seg_n},      32'h7F);
        check("rst_dp",  {31'd0, dp_n},       32'd1);
        check("rst_fd",  {31'd0, frame_done}, 32'd0);

        // Release: two dead cycles before digit 0 lights
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_dead_an", {28'd0, an_n}, 32'hF);
        @(negedge clk);
        check("rel_on_an",  {28'd0, an_n},  32'hE);
        check("rel_on_seg", {25'd0, seg_n}, 32'h40);
        check("rel_on_dp",  {31'd0, dp_n},  32'd1);

        // Asynchronous reset mid-ON blanks without a clock edge
        #2 rst_n = 1'b0;
        #1;
        check("arst_an",  {28'd0, an_n},  32'hF);
        check("arst_seg", {25'd0, seg_n}, 32'h7F);
        check("arst_dp",  {31'd0, dp_n},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel2_dead_an", {28'd0, an_n}, 32'hF);
        @(negedge clk);
        check("rel2_on_an", {28'd0, an_n}, 32'hE);

        // Load and scan
        load = 1'b1; value = 16'h12AF; dp_in = 4'b0100; blank_lz = 1'b0;
        @(negedge clk);
        load = 1'b0;
        wait_frame_done();
        check_frame("scan", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b0100, 1'b0, 0, 16'h0);

        // Leading-zero blanking (loads coincide with frame_done)
        load = 1'b1; value = 16'h0005; dp_in = 4'd0; blank_lz = 1'b1;
        check_frame("lz5", {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'd0, 1'b0, 0, 16'h0);
        load = 1'b1; value = 16'h0000; dp_in = 4'd0; blank_lz = 1'b1;
        check_frame("lz0", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'd0, 1'b0, 0, 16'h0);

        // Boundary load: 1111 mid-frame, then 2222 in the frame_done cycle
        @(negedge clk);
        load = 1'b1; value = 16'h1111; dp_in = 4'd0; blank_lz = 1'b0;
        @(negedge clk);
        load = 1'b0;
        wait_frame_done();
        load = 1'b1; value = 16'h2222; dp_in = 4'd0; blank_lz = 1'b0;
        check_frame("bnd", {7'h24, 7'h24, 7'h24, 7'h24}, 4'd0, 1'b0, 0, 16'h0);
        check_frame("bnd2", {7'h24, 7'h24, 7'h24, 7'h24}, 4'd0, 1'b0, 0, 16'h0);

        // Mid-frame load during digit 1 ON: current frame unchanged
        check_frame("mid", {7'h24, 7'h24, 7'h24, 7'h24}, 4'd0, 1'b1, 11, 16'h8888);
        check_frame("mid_next", {7'h00, 7'h00, 7'h00, 7'h00}, 4'd0, 1'b0, 0, 16'h0);

        // Frame pulse: 10 single-cycle pulses, 32 clocks apart
        pulses = 0;
        last   = 0;
        for (int k = 1; k <= 320; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                pulses++;
                check("fd_spacing", k - last, 32);
                last = k;
            end
        end
        check("fd_count", pulses, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
